// File: rtl/pim_conv_pkg.sv
// Shared types and width helpers for the bit-serial KxK convolution PIM block.
package pim_conv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } pim_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Index width that never collapses to zero bits, so single-entry
    // configurations still get a usable port.
    function automatic int idx_w(input int count);
        return (count <= 1) ? 1 : clog2(count);
    endfunction

    // Result width: a full N-tap product sum at every plane, shifted through
    // DATA_W planes, fits without wrapping.
    function automatic int out_w(input int data_w, input int wgt_w, input int taps);
        return data_w + wgt_w + clog2(taps);
    endfunction

endpackage

// File: rtl/pim_bitplane_mac.sv
// One bit-plane of the in-memory MAC: AND activation bits with weights,
// sum the selected weights and clip to the ADC full-scale code.
module pim_bitplane_mac
    import pim_conv_pkg::*;
#(
    parameter int N     = 9,
    parameter int WGT_W = 8,
    parameter int ADC_P = 12
) (
    input  logic [N-1:0]       plane_bits,
    input  logic [N*WGT_W-1:0] wgt,
    output logic [ADC_P-1:0]   psum,
    output logic               sat
);

    localparam int SUMW = WGT_W + clog2(N);
    localparam int CMPW = ((SUMW > ADC_P) ? SUMW : ADC_P) + 1;
    localparam logic [CMPW-1:0] MAXV = (CMPW'(1) << ADC_P) - CMPW'(1);

    logic [CMPW-1:0] sum;

    // Accumulate every weight whose activation bit is set in this plane.
    always_comb begin
        sum = '0;
        for (int i = 0; i < N; i++) begin
            if (plane_bits[i]) begin
                sum = sum + CMPW'(wgt[i*WGT_W +: WGT_W]);
            end
        end
    end

    assign sat  = (sum > MAXV);
    assign psum = sat ? {ADC_P{1'b1}} : sum[ADC_P-1:0];

endmodule

// File: rtl/conv_kxk_bitserial_pim.sv
// Bit-serial KxK convolution with a flop-based weight store, one activation
// bit-plane per cycle (MSB first) and a registered result handshake.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | ready for activations; weight writes commit here only
// ST_COMPUTE | one bit-plane per cycle, plane_q counts down to 0
// ST_DONE    | first cycle loads the output register, then holds for out_ready
module conv_kxk_bitserial_pim
    import pim_conv_pkg::*;
#(
    parameter int  DATA_W = 8,
    parameter int  WGT_W  = 8,
    parameter int  KSIZE  = 3,
    parameter int  DEPTH  = 4,
    parameter int  ADC_P  = 12,
    localparam int N      = KSIZE * KSIZE,
    localparam int OUT_W  = out_w(DATA_W, WGT_W, N),
    localparam int AW     = idx_w(DEPTH),
    localparam int TW     = idx_w(N)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [N*DATA_W-1:0] in_data,
    input  logic [AW-1:0]       in_addr,
    input  logic                w_we,
    input  logic [AW-1:0]       w_addr,
    input  logic [TW-1:0]       w_tap,
    input  logic [WGT_W-1:0]    w_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_W-1:0]    out_data,
    output logic                out_sat
);

    localparam int PW     = idx_w(DATA_W);
    localparam int WSET_W = N * WGT_W;

    pim_state_t              state_q, state_d;
    logic [N*DATA_W-1:0]     din_q, din_d;
    logic [WSET_W-1:0]       wsnap_q, wsnap_d;
    logic [DEPTH*WSET_W-1:0] wmem_q, wmem_d;
    logic [OUT_W-1:0]        acc_q, acc_d;
    logic                    sat_q, sat_d;
    logic [PW-1:0]           plane_q, plane_d;
    logic                    out_valid_q, out_valid_d;
    logic [OUT_W-1:0]        out_data_q, out_data_d;
    logic                    out_sat_q, out_sat_d;

    logic [WSET_W-1:0]       wsnap_sel;
    logic [N*DATA_W-1:0]     din_shift;
    logic [N-1:0]            plane_bits;
    logic [ADC_P-1:0]        mac_psum;
    logic                    mac_sat;

    // Weight store update; out-of-range set or tap indices never match a slot.
    always_comb begin
        wmem_d = wmem_q;
        for (int a = 0; a < DEPTH; a++) begin
            for (int t = 0; t < N; t++) begin
                if (w_we && (state_q == ST_IDLE) && (w_addr == AW'(a)) && (w_tap == TW'(t))) begin
                    wmem_d[(a*N+t)*WGT_W +: WGT_W] = w_data;
                end
            end
        end
    end

    // Kernel set selection; an address past DEPTH yields an all-zero set.
    always_comb begin
        wsnap_sel = '0;
        for (int a = 0; a < DEPTH; a++) begin
            if (in_addr == AW'(a)) begin
                wsnap_sel = wmem_q[a*WSET_W +: WSET_W];
            end
        end
    end

    // Pick the current bit-plane out of every latched activation.
    always_comb begin
        din_shift  = din_q >> plane_q;
        plane_bits = '0;
        for (int i = 0; i < N; i++) begin
            plane_bits[i] = din_shift[i*DATA_W];
        end
    end

    pim_bitplane_mac #(
        .N     (N),
        .WGT_W (WGT_W),
        .ADC_P (ADC_P)
    ) u_mac (
        .plane_bits (plane_bits),
        .wgt        (wsnap_q),
        .psum       (mac_psum),
        .sat        (mac_sat)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        din_d       = din_q;
        wsnap_d     = wsnap_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        plane_d     = plane_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    din_d   = in_data;
                    wsnap_d = wsnap_sel;
                    acc_d   = '0;
                    sat_d   = 1'b0;
                    plane_d = PW'(DATA_W - 1);
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                acc_d = (acc_q << 1) + OUT_W'(mac_psum);
                sat_d = sat_q | mac_sat;
                if (plane_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    plane_d = plane_q - 1'b1;
                end
            end
            ST_DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = acc_q;
                    out_sat_d   = sat_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and storage registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            din_q       <= '0;
            wsnap_q     <= '0;
            wmem_q      <= '0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            plane_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            din_q       <= din_d;
            wsnap_q     <= wsnap_d;
            wmem_q      <= wmem_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            plane_q     <= plane_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_conv_kxk_bitserial_pim.sv
// Scoreboard bench: two lockstep instances (ADC_P=12 and ADC_P=8) share all
// inputs; expected results are queued at issue and compared at out_valid.
module tb_conv_kxk_bitserial_pim;

    localparam int N  = 9;
    localparam int DW = 8;
    localparam int WW = 8;
    localparam int OW = 20;

    typedef struct packed {
        logic [OW-1:0] d;
        logic          s;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready, in_ready8;
    logic [N*DW-1:0] in_data;
    logic [1:0]    in_addr;
    logic          w_we;
    logic [1:0]    w_addr;
    logic [3:0]    w_tap;
    logic [WW-1:0] w_data;
    logic          out_valid, out_valid8;
    logic          out_ready;
    logic [OW-1:0] out_data, out_data8;
    logic          out_sat, out_sat8;

    int checks = 0;
    int errors = 0;

    logic [WW-1:0] wm [4][N];
    exp_t sb[$];
    exp_t sb8[$];

    always #5 clk = ~clk;

    conv_kxk_bitserial_pim dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_addr(in_addr),
        .w_we(w_we), .w_addr(w_addr), .w_tap(w_tap), .w_data(w_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    conv_kxk_bitserial_pim #(.ADC_P(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data), .in_addr(in_addr),
        .w_we(w_we), .w_addr(w_addr), .w_tap(w_tap), .w_data(w_data),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out_data8), .out_sat(out_sat8)
    );

    function automatic exp_t model(input int a, input logic [N*DW-1:0] d, input int adcp);
        exp_t   r;
        longint acc;
        longint p;
        longint maxv;
        logic   s;
        acc  = 0;
        s    = 1'b0;
        maxv = (longint'(1) << adcp) - 1;
        for (int pl = DW - 1; pl >= 0; pl--) begin
            p = 0;
            for (int i = 0; i < N; i++) begin
                if (d[i*DW+pl]) p = p + longint'(wm[a][i]);
            end
            if (p > maxv) begin
                p = maxv;
                s = 1'b1;
            end
            acc = acc * 2 + p;
        end
        r.d = OW'(acc);
        r.s = s;
        return r;
    endfunction

    function automatic logic [N*DW-1:0] rand_data();
        logic [N*DW-1:0] d;
        for (int i = 0; i < N; i++) d[i*DW +: DW] = DW'($urandom_range(0, 255));
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input int a, input int t, input int v, input bit commit);
        w_we   = 1'b1;
        w_addr = a[1:0];
        w_tap  = t[3:0];
        w_data = v[7:0];
        tick();
        w_we = 1'b0;
        if (commit && t < N) wm[a][t] = v[7:0];
    endtask

    task automatic push_model(input int a, input logic [N*DW-1:0] d);
        sb.push_back(model(a, d, 12));
        sb8.push_back(model(a, d, 8));
    endtask

    task automatic push_lit(input logic [OW-1:0] d12, input logic s12, input logic [OW-1:0] d8, input logic s8);
        exp_t e;
        e.d = d12; e.s = s12; sb.push_back(e);
        e.d = d8;  e.s = s8;  sb8.push_back(e);
    endtask

    task automatic start_op(input int a, input logic [N*DW-1:0] d, input bit use_model);
        if (use_model) push_model(a, d);
        in_valid = 1'b1;
        in_addr  = a[1:0];
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input int exp_lat, input int stall);
        int   cnt;
        exp_t e;
        exp_t e8;
        cnt = 0;
        while (!out_valid && cnt < 40) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_in_ready: got %b want 0", name, in_ready);
            end
            tick();
            cnt++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: out_valid got %b want 1 within 40 cycles", name, out_valid);
            if (sb.size() > 0) void'(sb.pop_front());
            if (sb8.size() > 0) void'(sb8.pop_front());
            return;
        end
        checks++;
        if (cnt != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", name, cnt, exp_lat);
        end
        checks++;
        if (sb.size() == 0 || sb8.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard_empty: got %0d entries want >0", name, sb.size());
            return;
        end
        e  = sb.pop_front();
        e8 = sb8.pop_front();
        checks++;
        if (out_data !== e.d || out_sat !== e.s) begin
            errors++;
            $display("FAIL %s result12: got %0d sat %b want %0d sat %b", name, out_data, out_sat, e.d, e.s);
        end
        checks++;
        if (out_valid8 !== 1'b1 || out_data8 !== e8.d || out_sat8 !== e8.s) begin
            errors++;
            $display("FAIL %s result8: got v%b %0d sat %b want v1 %0d sat %b", name, out_valid8, out_data8, out_sat8, e8.d, e8.s);
        end
        for (int s = 0; s < stall; s++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== e.d || out_sat !== e.s || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s stall%0d: got v%b %0d sat %b rdy %b want v1 %0d sat %b rdy 0",
                         name, s, out_valid, out_data, out_sat, in_ready, e.d, e.s);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || in_ready8 !== 1'b1) begin
            errors++;
            $display("FAIL %s release: got v%b rdy %b rdy8 %b want v0 rdy 1 rdy8 1", name, out_valid, in_ready, in_ready8);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: got v%b d%0d s%b rdy%b want v0 d0 s0 rdy1", out_valid, out_data, out_sat, in_ready);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got rdy%b v%b want rdy1 v0", in_ready, out_valid);
        end
    endtask

    task automatic test_ones();
        for (int t = 0; t < N; t++) write_w(0, t, 1, 1'b1);
        push_lit(20'd9, 1'b0, 20'd9, 1'b0);
        start_op(0, {N{8'h01}}, 1'b0);
        wait_result("ones", 9, 0);
    endtask

    task automatic test_max();
        for (int t = 0; t < N; t++) write_w(2, t, 255, 1'b1);
        push_lit(20'd585225, 1'b0, 20'd65025, 1'b1);
        start_op(2, {N{8'hFF}}, 1'b0);
        wait_result("max", 9, 0);
    endtask

    task automatic test_stall();
        start_op(0, rand_data(), 1'b1);
        wait_result("stall", 9, 5);
    endtask

    task automatic test_write_guard();
        logic [N*DW-1:0] d;
        for (int t = 0; t < N; t++) write_w(1, t, t + 1, 1'b1);
        d = rand_data();
        d[4*DW +: DW] = 8'hFF;
        start_op(1, d, 1'b1);
        write_w(1, 4, 7, 1'b0);
        wait_result("wr_in_compute", 8, 0);
        start_op(1, d, 1'b1);
        wait_result("wr_in_compute_after", 9, 0);
        // Same-cycle write and accept: snapshot must hold the old tap 4.
        push_model(1, d);
        in_valid = 1'b1; in_addr = 2'd1; in_data = d;
        w_we = 1'b1; w_addr = 2'd1; w_tap = 4'd4; w_data = 8'd7;
        tick();
        in_valid = 1'b0;
        w_we = 1'b0;
        wm[1][4] = 8'd7;
        wait_result("same_cycle_old", 9, 0);
        start_op(1, d, 1'b1);
        wait_result("same_cycle_new", 9, 0);
        // Taps past N must not land in the neighbouring set.
        write_w(1, 9, 99, 1'b0);
        write_w(1, 15, 99, 1'b0);
        start_op(2, rand_data(), 1'b1);
        wait_result("tap_guard_set2", 9, 0);
        start_op(1, rand_data(), 1'b1);
        wait_result("tap_guard_set1", 9, 0);
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < N; t++) write_w(3, t, $urandom_range(0, 255), 1'b1);
        for (int k = 0; k < 4; k++) begin
            start_op(3, rand_data(), 1'b1);
            wait_result("b2b", 9, 0);
        end
    endtask

    task automatic test_reset_mid();
        start_op(2, {N{8'hFF}}, 1'b0);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_outputs: got v%b d%0d s%b rdy%b want v0 d0 s0 rdy1", out_valid, out_data, out_sat, in_ready);
        end
        checks++;
        if (dut.wmem_q !== '0 || dut8.wmem_q !== '0) begin
            errors++;
            $display("FAIL reset_mid_weights: got %h want 0", dut.wmem_q);
        end
        for (int a = 0; a < 4; a++) for (int t = 0; t < N; t++) wm[a][t] = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || out_valid8 !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL reset_mid_quiet%0d: got v%b v8%b rdy%b want v0 v80 rdy1", c, out_valid, out_valid8, in_ready);
            end
        end
        push_lit(20'd0, 1'b0, 20'd0, 1'b0);
        start_op(2, {N{8'hFF}}, 1'b0);
        wait_result("post_reset_zero", 9, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_addr   = '0;
        w_we      = 1'b0;
        w_addr    = '0;
        w_tap     = '0;
        w_data    = '0;
        out_ready = 1'b0;
        for (int a = 0; a < 4; a++) for (int t = 0; t < N; t++) wm[a][t] = '0;
        test_reset();
        test_ones();
        test_max();
        test_stall();
        test_write_guard();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit reached want normal completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/conv_kxk_bitserial_pim.md
CONV_KXK_BITSERIAL_PIM -- requirements
Module: conv_kxk_bitserial_pim

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning activation width and bit-plane count.
REQ-002 The block SHALL have parameter WGT_W, default 8, meaning unsigned weight width.
REQ-003 The block SHALL have parameter KSIZE, default 3, meaning kernel edge; N = KSIZE*KSIZE taps.
REQ-004 The block SHALL have parameter DEPTH, default 4, meaning number of stored kernel sets.
REQ-005 The block SHALL have parameter ADC_P, default 12, meaning ADC output bits; per-plane partial sums saturate at 2^ADC_P-1.
REQ-006 The block SHALL have derived OUT_W = DATA_W+WGT_W+clog2(N), which is 20 at defaults.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; reset is asynchronous and active-low.
REQ-008 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-009 The block SHALL have port in_valid / in_ready, input / output, 1 bit each: activation handshake.
REQ-010 The block SHALL have port in_data, input, N*DATA_W bits: tap i at bits [i*DATA_W +: DATA_W], unsigned.
REQ-011 The block SHALL have port in_addr, input, clog2(DEPTH) bits: kernel set to use.
REQ-012 The block SHALL have port w_we, input, 1 bit; w_addr, clog2(DEPTH) bits; w_tap, clog2(N) bits; w_data, WGT_W bits: weight write port.
REQ-013 The block SHALL have port out_valid / out_ready, output / input, 1 bit each: result handshake.
REQ-014 The block SHALL have port out_data, output, OUT_W bits: convolution result.
REQ-015 The block SHALL have port out_sat, output, 1 bit: at least one plane saturated during this result.

Function
REQ-016 The FSM SHALL have states IDLE, COMPUTE and DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE, if in_valid=1, the block SHALL latch in_data, snapshot the N weights of set in_addr, clear acc and sat, set plane=DATA_W-1, and go to COMPUTE.
REQ-018 In COMPUTE, each cycle the block SHALL form p = sum over i of in_data_i[plane]*w_i, clip it to min(p, 2^ADC_P-1), and set sat |= (p > 2^ADC_P-1).
REQ-019 In COMPUTE, each cycle the block SHALL update acc = (acc<<1) + clipped p (MSB plane first); acc is OUT_W bits and SHALL NOT wrap at legal parameter values.
REQ-020 After plane 0 is processed, the block SHALL go to DONE; out_valid SHALL rise exactly DATA_W+1 clock edges after the acceptance edge (9 at defaults).
REQ-021 In DONE, out_data and out_sat SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 A DONE cycle with out_ready=1 SHALL complete the transfer; the next state SHALL be IDLE, so there is no back-to-back acceptance in the same cycle.
REQ-023 A w_we write SHALL be committed only in IDLE; in COMPUTE or DONE it SHALL be ignored and no stored weight changes.
REQ-024 If w_we and in_valid are both accepted in the same IDLE cycle, the write SHALL commit, and the computation SHALL use the pre-write snapshot.
REQ-025 A w_tap value >= N SHALL be ignored.
REQ-026 in_addr and w_addr values >= DEPTH SHALL be ignored: no write occurs, and for in_addr an all-zero weight set is used.

Reset
REQ-027 rst_n=0 SHALL asynchronously force the state to IDLE, out_valid=0, out_data=0, out_sat=0, acc=0, and all stored weights to 0.
REQ-028 A reset asserted during COMPUTE or DONE SHALL abort the operation with no output transfer; after rst_n deasserts, in_ready=1 on the first clock.

Structure
REQ-029 The FSM state enum, the clog2 function and the OUT_W derivation SHALL live in shared package pim_conv_pkg.
REQ-030 The per-plane AND-popcount-weight sum with ADC clip SHALL be the sub-module pim_bitplane_mac, combinational, parameters N, WGT_W and ADC_P, with outputs clipped sum and sat flag.
REQ-031 The weight store SHALL be flops: DEPTH*N*WGT_W bits.

Verification
REQ-032 At defaults, with all weights of set 0 equal to 1 and all inputs 1, the bench SHALL check out_data=9 and out_sat=0, with out_valid rising 9 edges after acceptance.
REQ-033 At defaults, with all weights 255 and all inputs 255, the bench SHALL check out_data=585225 and out_sat=0.
REQ-034 With ADC_P=8, all weights 255 and all inputs 255, the bench SHALL check out_data=65025 and out_sat=1.
REQ-035 The bench SHALL hold out_ready=0 for 5 cycles in DONE and check out_data stays stable and in_ready=0 throughout; after out_ready=1, in_ready=1 on the next cycle.
REQ-036 The bench SHALL write w_data=7 to set 1, tap 4 during COMPUTE and check the result is unchanged; a same-cycle write and accept in IDLE SHALL use the old weight.
REQ-037 The bench SHALL pulse rst_n low mid-COMPUTE and check out_valid=0, out_data=0 and weights=0 immediately, and no spurious out_valid afterwards.
